// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU memory channel initiator: channel FSM states and
// the consumer index width used by the arbiter and owner registers.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } chan_state_t;

    localparam int NUM_CONSUMERS_MAX = 8;
    localparam int CONS_IDX_W        = $clog2(NUM_CONSUMERS_MAX);

endpackage

// File: rtl/mem_channel_initiator_rr_arbiter.sv
// Round-robin picker: returns the first pending requester at or after ptr,
// scanning upward with wrap, as a one-hot grant plus its index.
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_REQ = 8
) (
    input  logic [NUM_REQ-1:0]    pending,
    input  logic [CONS_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [CONS_IDX_W-1:0] grant_idx,
    output logic                  grant_valid
);

    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!grant_valid && pending[j]) begin
                grant[j]    = 1'b1;
                grant_idx   = CONS_IDX_W'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_channel_initiator.sv
// Requester side of the GPU memory channel: round-robin arbitration of consumer
// requests onto memory channels, each channel running its own handshake FSM.
module mem_channel_initiator
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter bit WRITE_EN      = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int IDX_W = CONS_IDX_W;

    logic [NUM_CONSUMERS-1:0] wr_req, pending, busy_q, busy_d;
    logic [NUM_CHANNELS-1:0]  chan_ready, take;
    logic [IDX_W-1:0]         grant_idx [NUM_CHANNELS];
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    chan_state_t              state_q [NUM_CHANNELS];
    chan_state_t              state_d [NUM_CHANNELS];
    logic [IDX_W-1:0]         owner_q [NUM_CHANNELS];
    logic [IDX_W-1:0]         owner_d [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]                 mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_q, mem_write_address_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_ready_q, consumer_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;

    assign wr_req     = WRITE_EN ? consumer_write_valid : '0;
    assign pending    = (consumer_read_valid | wr_req) & ~busy_q;
    assign chan_ready = mem_read_ready | (WRITE_EN ? mem_write_ready : '0);

    // Each channel sees the pending vector minus consumers already taken by lower channels.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] pend_in, pend_out, grant;
        logic [IDX_W-1:0]         idx;
        logic                     gvalid, take_l;

        if (c == 0) begin : g_first
            assign pend_in = pending;
        end else begin : g_next
            assign pend_in = g_ch[c-1].pend_out;
        end

        rr_arbiter #(.NUM_REQ(NUM_CONSUMERS)) u_arb (
            .pending     (pend_in),
            .ptr         (rr_ptr_q),
            .grant       (grant),
            .grant_idx   (idx),
            .grant_valid (gvalid)
        );

        assign take_l       = gvalid && (state_q[c] == IDLE);
        assign pend_out     = take_l ? (pend_in & ~grant) : pend_in;
        assign take[c]      = take_l;
        assign grant_idx[c] = idx;
    end

    always_comb begin
        state_d              = state_q;
        owner_d              = owner_q;
        busy_d               = busy_q;
        rr_ptr_d             = rr_ptr_q;
        mem_read_valid_d     = mem_read_valid_q;
        mem_read_address_d   = mem_read_address_q;
        mem_write_valid_d    = mem_write_valid_q;
        mem_write_address_d  = mem_write_address_q;
        mem_write_data_d     = mem_write_data_q;
        consumer_ready_d     = '0;
        consumer_read_data_d = consumer_read_data_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                IDLE: begin
                    if (take[c]) begin
                        owner_d[c]             = grant_idx[c];
                        busy_d[grant_idx[c]]   = 1'b1;
                        rr_ptr_d               = IDX_W'((int'(grant_idx[c]) + 1) % NUM_CONSUMERS);
                        if (consumer_read_valid[grant_idx[c]]) begin
                            mem_read_valid_d[c]   = 1'b1;
                            mem_read_address_d[c] = consumer_read_address[grant_idx[c]];
                            state_d[c]            = READ_WAIT;
                        end else if (WRITE_EN) begin
                            mem_write_valid_d[c]   = 1'b1;
                            mem_write_address_d[c] = consumer_write_address[grant_idx[c]];
                            mem_write_data_d[c]    = consumer_write_data[grant_idx[c]];
                            state_d[c]             = WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        consumer_read_data_d[owner_q[c]] = mem_read_data[c];
                        consumer_ready_d[owner_q[c]]     = 1'b1;
                        mem_read_valid_d[c]              = 1'b0;
                        state_d[c]                       = RELEASE;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        consumer_ready_d[owner_q[c]] = 1'b1;
                        mem_write_valid_d[c]         = 1'b0;
                        state_d[c]                   = RELEASE;
                    end
                end
                RELEASE: begin
                    // Memory ready lags valid by a cycle; wait it out and for the owner to drop its request.
                    if (!chan_ready[c] && !consumer_read_valid[owner_q[c]] && !wr_req[owner_q[c]]) begin
                        busy_d[owner_q[c]] = 1'b0;
                        state_d[c]         = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                owner_q[c] <= '0;
            end
            busy_q               <= '0;
            rr_ptr_q             <= '0;
            mem_read_valid_q     <= '0;
            mem_read_address_q   <= '0;
            mem_write_valid_q    <= '0;
            mem_write_address_q  <= '0;
            mem_write_data_q     <= '0;
            consumer_ready_q     <= '0;
            consumer_read_data_q <= '0;
        end else begin
            state_q              <= state_d;
            owner_q              <= owner_d;
            busy_q               <= busy_d;
            rr_ptr_q             <= rr_ptr_d;
            mem_read_valid_q     <= mem_read_valid_d;
            mem_read_address_q   <= mem_read_address_d;
            mem_write_valid_q    <= mem_write_valid_d;
            mem_write_address_q  <= mem_write_address_d;
            mem_write_data_q     <= mem_write_data_d;
            consumer_ready_q     <= consumer_ready_d;
            consumer_read_data_q <= consumer_read_data_d;
        end
    end

    assign consumer_ready     = consumer_ready_q;
    assign consumer_read_data = consumer_read_data_q;
    assign mem_read_valid     = mem_read_valid_q;
    assign mem_read_address   = mem_read_address_q;
    assign mem_write_valid    = WRITE_EN ? mem_write_valid_q   : '0;
    assign mem_write_address  = WRITE_EN ? mem_write_address_q : '0;
    assign mem_write_data     = WRITE_EN ? mem_write_data_q    : '0;

endmodule

// File: tb/tb_mem_channel_initiator.sv
// Scoreboard bench for mem_channel_initiator: a 4-channel read/write instance
// and a 1-channel read-only instance, each answered by a registered-ready memory.
module tb_mem_channel_initiator;
    import gpu_mem_pkg::*;

    localparam int NC  = 8;
    localparam int NCH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]          rv, wv, crdy;
    logic [NC-1:0][7:0]     ra, wa, wd, crd;
    logic [NCH-1:0]         mrv, mrr, mwv, mwr;
    logic [NCH-1:0][7:0]    mra, mrd, mwa, mwd;

    logic [NC-1:0]          rv1, wv1, crdy1;
    logic [NC-1:0][7:0]     ra1, wa1, wd1, crd1;
    logic [0:0]             mrv1, mrr1, mwv1, mwr1;
    logic [0:0][7:0]        mra1, mrd1, mwa1, mwd1;

    mem_channel_initiator #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(8),
                            .DATA_BITS(8), .WRITE_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
        .consumer_ready(crdy), .consumer_read_data(crd),
        .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    mem_channel_initiator #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(8),
                            .DATA_BITS(8), .WRITE_EN(1'b0)) u_dut_ro (
        .clk(clk), .rst_n(rst_n),
        .consumer_read_valid(rv1), .consumer_read_address(ra1),
        .consumer_write_valid(wv1), .consumer_write_address(wa1), .consumer_write_data(wd1),
        .consumer_ready(crdy1), .consumer_read_data(crd1),
        .mem_read_valid(mrv1), .mem_read_address(mra1), .mem_read_ready(mrr1), .mem_read_data(mrd1),
        .mem_write_valid(mwv1), .mem_write_address(mwa1), .mem_write_data(mwd1), .mem_write_ready(mwr1)
    );

    // External memory: base content a^0x06 unless written; ready is registered from valid.
    logic [7:0]   wmem [256];
    logic [255:0] wset = '0;
    int           stall = 0;
    int           extra = 0;
    int           rcnt [NCH];

    function automatic logic [7:0] mem_rd(logic [7:0] a);
        return wset[a] ? wmem[a] : (a ^ 8'h06);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrr <= '0;
            mwr <= '0;
            for (int c = 0; c < NCH; c++) rcnt[c] <= 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (mrv[c] && stall == 0) begin
                    mrr[c]  <= 1'b1;
                    mrd[c]  <= mem_rd(mra[c]);
                    rcnt[c] <= extra;
                end else if (mrr[c] && rcnt[c] > 0) begin
                    mrr[c]  <= 1'b1;
                    mrd[c]  <= 8'hEE;
                    rcnt[c] <= rcnt[c] - 1;
                end else begin
                    mrr[c] <= 1'b0;
                end
                if (mwv[c]) begin
                    mwr[c]         <= 1'b1;
                    wmem[mwa[c]]   <= mwd[c];
                    wset[mwa[c]]   <= 1'b1;
                end else begin
                    mwr[c] <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrr1 <= '0;
        end else begin
            mrr1    <= mrv1;
            mrd1[0] <= mra1[0] ^ 8'hFF;
        end
    end

    typedef struct {
        int         cons;
        logic [7:0] data;
    } ent_t;

    ent_t       sbq [$];
    logic [7:0] shadow [256];
    logic [7:0] last_rd [NC];
    int         pulse_cnt [NC];
    int         hold1 [NC];
    bit         fair_on = 1'b0;
    logic       prev_mrv1 = 1'b0;
    logic [7:0] fair_grants [$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: scoreboard completions, consumers drop requests on their ready pulse.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (crdy[i] === 1'b1) begin
                int k;
                k = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (k < 0 && sbq[j].cons == i) k = j;
                pulse_cnt[i]++;
                if (k < 0) begin
                    check_eq($sformatf("spurious_ready_c%0d", i), 1, 0);
                end else begin
                    check_eq($sformatf("rdata_c%0d", i), crd[i], sbq[k].data);
                    last_rd[i] = sbq[k].data;
                    sbq.delete(k);
                end
                rv[i] = 1'b0;
                wv[i] = 1'b0;
            end
            if (crdy1[i] === 1'b1) begin
                check_eq($sformatf("ro_rdata_c%0d", i), crd1[i], ra1[i] ^ 8'hFF);
                hold1[i] = 3;
            end else if (hold1[i] > 0) begin
                hold1[i]--;
            end
            rv1[i] = fair_on && (i == 0 || i == 5) && (hold1[i] == 0);
        end
        if (mrv1[0] && !prev_mrv1) fair_grants.push_back(mra1[0]);
        prev_mrv1 = mrv1[0];
    endtask

    task automatic rd(int i, logic [7:0] a);
        ra[i] = a;
        rv[i] = 1'b1;
        sbq.push_back('{cons: i, data: shadow[a]});
    endtask

    task automatic wr(int i, logic [7:0] a, logic [7:0] d);
        wa[i] = a;
        wd[i] = d;
        wv[i] = 1'b1;
        sbq.push_back('{cons: i, data: last_rd[i]});
        shadow[a] = d;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_outstanding", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        rv1 = '0; wv1 = '1; wd1 = '1;
        for (int i = 0; i < NC; i++) begin
            ra1[i] = 8'h40 + 8'(i);
            wa1[i] = 8'h80 + 8'(i);
            last_rd[i] = 8'h00;
            pulse_cnt[i] = 0;
            hold1[i] = 0;
        end
        for (int a = 0; a < 256; a++) shadow[a] = 8'(a) ^ 8'h06;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_read_valid", mrv, 0);
        check_eq("rst_mem_read_addr", mra, 0);
        check_eq("rst_mem_write_valid", mwv, 0);
        check_eq("rst_consumer_ready", crdy, 0);
        check_eq("rst_consumer_rdata", crd, 0);
        check_eq("rst_ch0_state", u_dut.state_q[0], IDLE);
        rst_n = 1'b1;
        tick();

        // Single read: consumer 2, address 0x05 holds 0x03.
        rd(2, 8'h05);
        tick();
        check_eq("sr_mem_read_valid", mrv, 4'b0001);
        check_eq("sr_mem_read_addr", mra[0], 8'h05);
        tick();
        check_eq("sr_no_early_ready", crdy, 0);
        tick();
        check_eq("sr_ready_pulse", crdy, 8'b0000_0100);
        check_eq("sr_rdata", crd[2], 8'h03);
        check_eq("sr_valid_dropped", mrv, 0);
        check_eq("sr_state_release", u_dut.state_q[0], RELEASE);
        tick();
        check_eq("sr_still_release", u_dut.state_q[0], RELEASE);
        check_eq("sr_single_pulse", crdy, 0);
        tick();
        check_eq("sr_state_idle", u_dut.state_q[0], IDLE);
        check_eq("sr_pulse_count", pulse_cnt[2], 1);

        // Single write then readback.
        wr(1, 8'h0A, 8'h1E);
        tick();
        check_eq("sw_mem_write_valid", mwv, 4'b0001);
        check_eq("sw_mem_write_addr", mwa[0], 8'h0A);
        check_eq("sw_mem_write_data", mwd[0], 8'h1E);
        check_eq("sw_no_read", mrv, 0);
        drain(20);
        repeat (3) tick();
        rd(1, 8'h0A);
        drain(20);
        repeat (3) tick();

        // Stale ready held two cycles after valid drops.
        extra = 2;
        rd(3, 8'h33);
        drain(20);
        repeat (6) tick();
        extra = 0;
        check_eq("stale_rdata_kept", crd[3], 8'h35);
        check_eq("stale_pulse_count", pulse_cnt[3], 1);

        // Grant to consumer 7 wraps the pointer back to 0.
        rd(7, 8'h77);
        drain(20);
        repeat (3) tick();

        // Full load: all consumers at once.
        for (int i = 0; i < NC; i++) pulse_cnt[i] = 0;
        for (int i = 0; i < NC; i++) rd(i, 8'(i));
        tick();
        check_eq("fl_wave1_valid", mrv, 4'hF);
        for (int c = 0; c < NCH; c++) check_eq($sformatf("fl_wave1_addr_ch%0d", c), mra[c], c);
        got = 0;
        for (int n = 0; n < 30 && got == 0; n++) begin
            tick();
            if (mrv == 4'hF && mra[0] == 8'd4) got = 1;
        end
        check_eq("fl_wave2_seen", got, 1);
        for (int c = 0; c < NCH; c++) check_eq($sformatf("fl_wave2_addr_ch%0d", c), mra[c], 4 + c);
        drain(60);
        repeat (3) tick();
        for (int i = 0; i < NC; i++) check_eq($sformatf("fl_pulse_count_c%0d", i), pulse_cnt[i], 1);

        // Read and write together: read first, write must be re-presented.
        ra[6] = 8'h60; wa[6] = 8'h61; wd[6] = 8'h5A;
        rv[6] = 1'b1; wv[6] = 1'b1;
        sbq.push_back('{cons: 6, data: shadow[8'h60]});
        tick();
        check_eq("rw_read_first", mrv, 4'b0001);
        check_eq("rw_write_held", mwv, 0);
        drain(20);
        repeat (3) tick();
        wr(6, 8'h61, 8'h5A);
        tick();
        check_eq("rw_write_granted", mwv, 4'b0001);
        drain(20);
        repeat (3) tick();
        rd(6, 8'h61);
        drain(20);
        repeat (3) tick();

        // Fairness on the single-channel read-only instance.
        fair_on = 1'b1;
        repeat (40) tick();
        fair_on = 1'b0;
        repeat (10) tick();
        check_eq("fair_grant_count_ge4", fair_grants.size() >= 4, 1);
        for (int g = 0; g < 4; g++)
            check_eq($sformatf("fair_grant%0d", g), (g < fair_grants.size()) ? fair_grants[g] : 8'h00,
                     (g % 2 == 0) ? 8'h40 : 8'h45);
        check_eq("ro_write_valid_tied", mwv1, 0);
        check_eq("ro_write_addr_tied", mwa1, 0);
        check_eq("ro_write_data_tied", mwd1, 0);

        // Reset while a read is outstanding.
        stall = 1;
        rd(4, 8'h20);
        repeat (3) tick();
        check_eq("rr_in_read_wait", u_dut.state_q[0], READ_WAIT);
        check_eq("rr_valid_before", mrv, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rr_async_valid", mrv, 0);
        check_eq("rr_async_addr", mra, 0);
        check_eq("rr_async_ready", crdy, 0);
        check_eq("rr_async_rdata", crd, 0);
        rv = '0;
        sbq.delete();
        for (int i = 0; i < NC; i++) last_rd[i] = 8'h00;
        stall = 0;
        repeat (3) tick();
        check_eq("rr_state_idle", u_dut.state_q[0], IDLE);
        rst_n = 1'b1;
        tick();
        rd(4, 8'h21);
        drain(20);
        repeat (3) tick();
        check_eq("rr_fresh_rdata", crd[4], 8'h27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
